apb_rr_master_arbiter: RTL and testbench

//   Shares a single APB register-file slave among NUM_REQ internal requesters.

---
 rtl/apb_rr_master_arbiter.sv | 137 +++++++++++++
 tb/tb_apb_rr_master_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_master_arbiter.sv
// apb_rr_master_arbiter
// Round-robin arbiter that lets NUM_REQ internal requesters share one APB
// slave. Each accepted request becomes one APB SETUP/ACCESS transfer; the
// result returns on a one-cycle per-requester response pulse. Every output
// is a flop, so the APB bus and the response bus are glitch-free.

module apb_rr_master_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic                          psel,
    output logic                          penable,
    output logic                          pwrite,
    output logic [DATA_WIDTH-1:0]         pwdata,
    input  logic [DATA_WIDTH-1:0]         prdata,
    input  logic                          pready,
    input  logic                          pslverr
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] last;      // requester served most recently
    logic [IDX_W-1:0] gnt;       // requester owning the current transfer
    logic [IDX_W-1:0] next_gnt;
    logic             gnt_found;
    logic [IDX_W:0]   cand;      // one spare bit so last+1+i cannot overflow
    logic [CNT_W-1:0] wait_cnt;  // ACCESS cycles seen with pready low

    // Round-robin search: first valid requester starting just after 'last'.
    always_comb begin
        // NOTE: every variable gets a default before the loop, otherwise
        // paths that never assign it would infer a latch.
        next_gnt  = '0;
        gnt_found = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, last} + (IDX_W+1)'(i + 1);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!gnt_found && req_valid[cand[IDX_W-1:0]]) begin
                gnt_found = 1'b1;
                next_gnt  = cand[IDX_W-1:0];
            end
        end
    end

    // Transfer FSM with registered APB, handshake and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= IDX_W'(NUM_REQ - 1);
            gnt       <= '0;
            wait_cnt  <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            paddr     <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so the pulse
            // defaults below are simply overridden by later branch writes.
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        gnt                 <= next_gnt;
                        paddr               <= req_addr[int'(next_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
                        pwdata              <= req_wdata[int'(next_gnt)*DATA_WIDTH +: DATA_WIDTH];
                        pwrite              <= req_write[next_gnt];
                        req_ready[next_gnt] <= 1'b1;
                        psel                <= 1'b1;
                        penable             <= 1'b0;
                        state               <= SETUP;
                    end
                end
                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel           <= 1'b0;
                        penable        <= 1'b0;
                        rsp_valid[gnt] <= 1'b1;
                        rsp_err        <= pslverr;
                        rsp_rdata      <= pwrite ? '0 : prdata;
                        last           <= gnt;
                        state          <= IDLE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Slave never answered: abort with an error response.
                        psel           <= 1'b0;
                        penable        <= 1'b0;
                        rsp_valid[gnt] <= 1'b1;
                        rsp_err        <= 1'b1;
                        rsp_rdata      <= '0;
                        last           <= gnt;
                        state          <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// tb_apb_rr_master_arbiter
// Directed bench for the APB round-robin arbiter. Inputs change and outputs
// are sampled 1 time unit after each rising edge, so each "cycle" below is
// the register state visible between two edges.

module tb_apb_rr_master_arbiter;

    localparam int NUM_REQ = 4;
    localparam int AW      = 8;
    localparam int DW      = 32;
    localparam int TO      = 16;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [DW-1:0]         rsp_rdata;
    logic                  rsp_err;
    logic [AW-1:0]         paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DW-1:0]         pwdata;
    logic [DW-1:0]         prdata;
    logic                  pready;
    logic                  pslverr;

    int vectors;
    int miscompares;

    apb_rr_master_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_write[i]          = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    initial begin
        int order [7];
        order = '{0, 1, 2, 3, 0, 1, 3};
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_psel",      32'(psel),      32'h0);
        check("rst_penable",   32'(penable),   32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", rsp_rdata,      32'h0);
        check("rst_rsp_err",   32'(rsp_err),   32'h0);
        check("rst_paddr",     32'(paddr),     32'h0);
        check("rst_pwrite",    32'(pwrite),    32'h0);
        check("rst_pwdata",    pwdata,         32'h0);
        rst_n = 1'b1;

        // ---------------- round robin, all four valid ----------------
        // Pointer starts at 3, so grants run 0,1,2,3,0; then 0 and 2 drop,
        // leaving 1 then 3.
        pready = 1'b1;
        prdata = 32'h5555_AAAA;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b0, AW'(8'h10 + i), 32'h0);
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("rr%0d_req_ready", k), 32'(req_ready), 32'(1 << order[k]));
            check($sformatf("rr%0d_paddr", k),     32'(paddr),     32'(8'h10 + order[k]));
            if (k == 4) begin
                set_req(0, 1'b0, 1'b0, 8'h10, 32'h0);
                set_req(2, 1'b0, 1'b0, 8'h12, 32'h0);
            end
            if (k == 6) req_valid = '0;
            tick();
            tick();
            check($sformatf("rr%0d_rsp_valid", k), 32'(rsp_valid), 32'(1 << order[k]));
            check($sformatf("rr%0d_ready_low", k), 32'(req_ready), 32'h0);
        end

        // ---------------- write, req0, zero wait ----------------
        set_req(0, 1'b1, 1'b1, 8'h04, 32'hDEAD_BEEF);
        tick();  // N+1: SETUP
        check("wr_psel_setup",    32'(psel),      32'h1);
        check("wr_penable_setup", 32'(penable),   32'h0);
        check("wr_req_ready",     32'(req_ready), 32'b0001);
        check("wr_paddr",         32'(paddr),     32'h04);
        check("wr_pwrite",        32'(pwrite),    32'h1);
        check("wr_pwdata_setup",  pwdata,         32'hDEAD_BEEF);
        tick();  // N+2: ACCESS
        req_valid[0] = 1'b0;
        check("wr_penable_acc",   32'(penable),   32'h1);
        check("wr_psel_acc",      32'(psel),      32'h1);
        check("wr_pwdata_acc",    pwdata,         32'hDEAD_BEEF);
        check("wr_ready_acc",     32'(req_ready), 32'h0);
        tick();  // N+3: response
        check("wr_rsp_valid",     32'(rsp_valid), 32'b0001);
        check("wr_rsp_err",       32'(rsp_err),   32'h0);
        check("wr_rsp_rdata",     rsp_rdata,      32'h0);
        check("wr_psel_done",     32'(psel),      32'h0);
        check("wr_penable_done",  32'(penable),   32'h0);

        // ---------------- read, req2 ----------------
        prdata = 32'h1234_5678;
        set_req(2, 1'b1, 1'b0, 8'h08, 32'h0);
        tick();
        check("rd_req_ready",  32'(req_ready), 32'b0100);
        check("rd_paddr",      32'(paddr),     32'h08);
        check("rd_pwrite",     32'(pwrite),    32'h0);
        tick();
        req_valid[2] = 1'b0;
        tick();
        check("rd_rsp_valid",  32'(rsp_valid), 32'b0100);
        check("rd_rsp_rdata",  rsp_rdata,      32'h1234_5678);
        check("rd_rsp_err",    32'(rsp_err),   32'h0);
        prdata = 32'h0;
        tick();
        check("rd_rsp_pulse",  32'(rsp_valid), 32'h0);
        check("rd_rdata_hold", rsp_rdata,      32'h1234_5678);

        // ---------------- timeout, req3, pready stuck low ----------------
        pready = 1'b0;
        prdata = 32'hCAFE_F00D;
        set_req(3, 1'b1, 1'b0, 8'h30, 32'h0);
        tick();  // N+1
        check("to_req_ready", 32'(req_ready), 32'b1000);
        tick();  // N+2: first ACCESS cycle
        req_valid[3] = 1'b0;
        check("to_penable", 32'(penable), 32'h1);
        for (int c = 3; c <= 17; c++) begin
            tick();
            check($sformatf("to_wait%0d_rsp", c),  32'(rsp_valid), 32'h0);
            check($sformatf("to_wait%0d_psel", c), 32'(psel),      32'h1);
        end
        tick();  // N+18
        check("to_rsp_valid", 32'(rsp_valid), 32'b1000);
        check("to_rsp_err",   32'(rsp_err),   32'h1);
        check("to_rsp_rdata", rsp_rdata,      32'h0);
        check("to_psel",      32'(psel),      32'h0);

        // ---------------- wait states, req1, 3 low cycles ----------------
        prdata = 32'h0;
        set_req(1, 1'b1, 1'b1, 8'h20, 32'hA5A5_5A5A);
        tick();  // N+1
        check("ws_req_ready", 32'(req_ready), 32'b0010);
        tick();  // N+2: ACCESS, pready low
        set_req(1, 1'b0, 1'b0, 8'hFF, 32'h0);  // ignored after grant
        for (int c = 2; c <= 5; c++) begin
            if (c == 5) pready = 1'b1;
            check($sformatf("ws%0d_paddr", c),   32'(paddr),     32'h20);
            check($sformatf("ws%0d_pwrite", c),  32'(pwrite),    32'h1);
            check($sformatf("ws%0d_pwdata", c),  pwdata,         32'hA5A5_5A5A);
            check($sformatf("ws%0d_penable", c), 32'(penable),   32'h1);
            check($sformatf("ws%0d_rsp", c),     32'(rsp_valid), 32'h0);
            tick();
        end
        // N+6
        check("ws_rsp_valid", 32'(rsp_valid), 32'b0010);
        check("ws_rsp_err",   32'(rsp_err),   32'h0);
        check("ws_psel",      32'(psel),      32'h0);

        // ---------------- slave error on read, req0 ----------------
        pslverr = 1'b1;
        prdata  = 32'h0BAD_F00D;
        set_req(0, 1'b1, 1'b0, 8'h44, 32'h0);
        tick();
        check("se_req_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid[0] = 1'b0;
        tick();
        check("se_rsp_valid", 32'(rsp_valid), 32'b0001);
        check("se_rsp_err",   32'(rsp_err),   32'h1);
        check("se_rsp_rdata", rsp_rdata,      32'h0BAD_F00D);
        pslverr = 1'b0;
        prdata  = 32'h0;

        // ---------------- reset during ACCESS ----------------
        // Last served is req0, so without a pointer reset req1 would win next.
        pready = 1'b0;
        set_req(1, 1'b1, 1'b0, 8'h50, 32'h0);
        tick();
        check("rs_req_ready", 32'(req_ready), 32'b0010);
        tick();  // ACCESS
        check("rs_penable_pre", 32'(penable), 32'h1);
        set_req(0, 1'b1, 1'b0, 8'h60, 32'h0);
        rst_n = 1'b0;
        #1;
        check("rs_psel_async",    32'(psel),    32'h0);
        check("rs_penable_async", 32'(penable), 32'h0);
        tick();
        check("rs_no_rsp", 32'(rsp_valid), 32'h0);
        rst_n  = 1'b1;
        pready = 1'b1;
        tick();
        check("rs_regrant_req0", 32'(req_ready), 32'b0001);
        check("rs_regrant_addr", 32'(paddr),     32'h60);
        tick();
        req_valid = '0;
        tick();
        check("rs_rsp_valid", 32'(rsp_valid), 32'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
